// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder, LSB first, with valid/ready handshakes on input and output.
// Define SERIAL_ADDER_SUB_EN to honour the sub input (a - b via two's complement).
module half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [WIDTH-1:0] a_sh, b_sh, res, b_load;
  logic [CW-1:0] cnt;
  logic carry, c_load, s0, c0, s, c1, c;
  half_adder ha0 (.x(a_sh[0]), .y(b_sh[0]), .s(s0), .c(c0));
  half_adder ha1 (.x(s0), .y(carry), .s(s), .c(c1));
  assign c = c0 | c1;
`ifdef SERIAL_ADDER_SUB_EN
  assign b_load = sub ? ~b : b;
  assign c_load = sub;
`else
  logic unused_sub;
  assign unused_sub = sub;
  assign b_load = b;
  assign c_load = 1'b0;
`endif
  assign in_ready = state == IDLE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      a_sh      <= '0;
      b_sh      <= '0;
      res       <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_sh  <= a;
          b_sh  <= b_load;
          carry <= c_load;
          cnt   <= '0;
          state <= RUN;
        end
        RUN: begin
          res   <= {s, res[WIDTH-1:1]};
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          carry <= c;
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            sum       <= {s, res[WIDTH-1:1]};
            cout      <= c;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial WIDTH-bit adder built from the team's half-adder cell. Two half adders plus an OR form a full-adder slice, and a registered carry feeds that slice back to itself. The block accepts a pair of operands through a valid/ready handshake and processes one bit per clock, LSB first. It presents the sum and carry-out through a second valid/ready handshake. It is the sequential stage directly downstream of the half adder and trades latency for area against the parallel ripple adders.

## Interface
- WIDTH, 8, operand and sum width in bits; legal range WIDTH >= 2
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operands a/b (and sub) are valid
- in_ready  output  1  block can accept operands; high only in IDLE
- a  input  WIDTH  operand A, unsigned
- b  input  WIDTH  operand B, unsigned
- sub  input  1  subtract select; used only when SERIAL_ADDER_SUB_EN is defined
- out_valid  output  1  sum/cout hold a completed result
- out_ready  input  1  downstream accepts the result
- sum  output  WIDTH  registered result
- cout  output  1  registered carry out of bit WIDTH-1

## Operation
- States: IDLE, RUN, DONE. Encoding is free.
- IDLE
  - in_ready = 1.
  - On in_valid & in_ready at a rising edge: load shift registers A <= a and B <= b (B <= ~b when subtracting), carry <= 0 (carry <= 1 when subtracting), bit counter <= 0, go to RUN.
- RUN
  - Each edge: slice computes s = A[0]^B[0]^carry and c = (A[0]&B[0]) | (carry&(A[0]^B[0])).
  - s shifts into the MSB of the internal result register; A and B shift right; carry <= c; counter increments.
  - When the counter reaches WIDTH-1, that edge is the final bit:
    - sum <= completed result (including this bit);
    - cout <= c;
    - state <= DONE.
- DONE
  - out_valid = 1; sum and cout are stable.
  - On out_ready at a rising edge, go to IDLE.
  - No new operands are accepted in the same cycle as the output handshake.
- a, b and sub are sampled only at the input handshake; changes during RUN or DONE have no effect.
- sum/cout keep their last completed value through IDLE and RUN until the next DONE entry.
- Counter width is $clog2(WIDTH).

## Timing
- Reset values (asserted or just released):
  - state IDLE, in_ready = 1;
  - out_valid = 0, sum = 0, cout = 0;
  - internal shift registers, carry and counter = 0.
- Reset asserted mid-RUN or mid-DONE aborts the operation. The result is discarded and out_valid never rises for it.
- Latency: input handshake at edge k, then out_valid is high from edge k+WIDTH until the edge where out_ready is sampled high.
- Throughput: at most one operation per WIDTH+2 cycles, with out_ready held high.
- Back-pressure: out_ready low holds DONE indefinitely with outputs frozen.
- in_ready is combinational from state only; it has no dependency on in_valid.
- out_valid is a registered state decode.

## Configuration
- Macro: SERIAL_ADDER_SUB_EN
- Defined, with sub = 1 at accept: computes a - b by two's complement (B loaded as ~b, carry-in 1).
  - sum = (a - b) mod 2^WIDTH.
  - cout = 1 means no borrow (a >= b).
- Defined, with sub = 0: plain addition.
- Undefined: sub port is present but ignored. Carry-in is always 0, B is always loaded as b, and no inversion logic is synthesised.

## Test plan
- Reset: assert rst for 3 cycles mid-stream, then release -> in_ready = 1, out_valid = 0, sum = 8'h00, cout = 0.
- Basic add, WIDTH = 8: a = 8'h3C, b = 8'h0A, in_valid for 1 cycle -> out_valid rises exactly 8 edges after accept; sum = 8'h46, cout = 0; in_ready = 0 throughout RUN/DONE.
- Full carry chain: a = 8'hFF, b = 8'h01 -> sum = 8'h00, cout = 1. Then a = 8'hFF, b = 8'hFF -> sum = 8'hFE, cout = 1.
- Back-pressure and input isolation:
  - out_ready low for 5 cycles after out_valid -> sum/cout/out_valid unchanged;
  - toggling a/b/in_valid during RUN and DONE has no effect;
  - raising out_ready -> in_ready high on the next cycle.
- Abort: assert rst 4 cycles into RUN of a = 8'h12, b = 8'h34 -> outputs return to reset values and no out_valid occurs. Then a new operation a = 8'h01, b = 8'h02 -> sum = 8'h03.
- Subtract, with the macro defined: a = 8'h05, b = 8'h07, sub = 1 -> sum = 8'hFE, cout = 0. a = 8'h07, b = 8'h05 -> sum = 8'h02, cout = 1.
- Subtract, without the macro: a = 8'h05, b = 8'h07, sub = 1 -> sum = 8'h0C, cout = 0.
